dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the CPU's MemR/MemW control strobes.
- Accepts one word read or write at a time from the datapath, inserts a programmable number of wait states, then performs the access on an internal word array.
- Returns read data with a single-cycle ready pulse, which the CPU uses to gate PCW and stall until completion.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- AW, 10, word-index width, equal to log2(DEPTH).
- WAIT_CYCLES, 2, wait states inserted before each access (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- mem_r  input  1  read request (MemR control bit).
- mem_w  input  1  write request (MemW control bit).
- addr  input  32  byte address from the ALU result.
- wdata  input  32  store data (rt value).
- rdata  output  32  load data, valid while ready=1.
- ready  output  1  transaction complete, one-cycle pulse.
- busy  output  1  high while a transaction is in flight (WAIT or DONE).
- err  output  1  misaligned-access flag; exists only with DMEM_ALIGN_CHECK_EN.

Behaviour:
- All outputs are registered.
- Reset values: rdata=0, ready=0, busy=0, err=0, state=IDLE, cnt=0.
- Array contents are not reset.
- Word index is addr[AW+1:2]. Addresses beyond DEPTH wrap modulo DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If mem_w|mem_r at the edge: latch index, wdata and op (write if mem_w, else read); load cnt=WAIT_CYCLES; go to WAIT; busy=1.
  - If mem_r and mem_w are both high, the request is a write. rdata is unchanged.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0, perform the access: write commits to the array at this edge, or read captures array[index] into rdata. Go to DONE, ready=1.
- DONE:
  - ready is high for exactly this one cycle.
  - Next edge: ready=0, busy=0, go to IDLE.
  - Requests are ignored in DONE. The CPU must drop or change its request in the cycle after ready.
- Latency: accept edge N, then ready is high in the cycle after edge N+WAIT_CYCLES+1.
  - WAIT_CYCLES=0 gives ready after 2 edges.
- Requests are sampled only in IDLE. Changes to addr, wdata, mem_r or mem_w during WAIT have no effect.
- Back-to-back transactions have a minimum one-cycle IDLE gap.
- rdata holds its last read value until the next read completes. A write never alters rdata.
- Reset mid-operation: FSM returns to IDLE. An uncommitted write is dropped. No ready pulse is produced for the aborted transaction.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a request with addr[1:0]!=0 goes to WAIT normally.
  - At access time the write is suppressed and a read returns 0.
  - err=1 during the DONE cycle together with ready.
  - err resets to 0.
- Undefined:
  - addr[1:0] is ignored and the err port is absent.

Decomposition:
- Shared package cpu_pkg:
  - Control-word bit-position constants: SIG_MEMR=4, SIG_MEMW=3, SIG_PCW=0, SIG_PCWC=1, etc.
  - Width constant SIG_W=13.
  - FSM state encoding for this block: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
- One sub-module, dmem_array:
  - Single-port synchronous RAM with DEPTH/AW parameters.
  - Ports: clk, we, idx, din, dout.
  - Write-first is not required; read and write are never issued in the same cycle.

Test Plan:
- WAIT_CYCLES=2, rst then write: mem_w=1, addr=0x10, wdata=0xDEADBEEF at edge 0 → ready=1 only in cycle 4, busy=1 in cycles 1–4, rdata stays 0.
- Read back: mem_r=1, addr=0x10 → ready pulse after 4 edges with rdata=0xDEADBEEF; rdata persists at 0xDEADBEEF after ready falls.
- Wrap and priority: DEPTH=1024, write 0x12345678 to addr=0x1010, then read addr=0x0010 → rdata=0x12345678. Separately, mem_r=mem_w=1 with wdata=0xA5A5A5A5 at addr=0x20 → write occurs, rdata unchanged.
- Reset mid-write: mem_w to addr=0x30 with wdata=0x1, assert rst during WAIT → no ready pulse, busy=0; a later read of 0x30 returns the prior content (0 after the initial test write pattern).
- WAIT_CYCLES=0 back-to-back: write 0x5 to 0x40, read 0x40 immediately after the ready cycle → each ready appears 2 edges after accept, read returns 0x5, with one IDLE cycle between transactions.
- DMEM_ALIGN_CHECK_EN defined: mem_w at addr=0x42 with wdata=0xFF → err=1 and ready=1 together; a subsequent read of 0x40 does not return 0xFF, and a read of 0x43 returns 0 with err=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Definitions shared by the CPU control path and the data-memory responder:
//   - bit positions of the multi-cycle control word (SIG_*), width SIG_W
//   - state encoding of the dmem_responder FSM
//   - a small helper that flags a misaligned word address
// ---------------------------------------------------------------------------
package cpu_pkg;

    // Control-word layout
    localparam int SIG_W       = 13;
    localparam int SIG_PCW     = 0;
    localparam int SIG_PCWC    = 1;
    localparam int SIG_IORD    = 2;
    localparam int SIG_MEMW    = 3;
    localparam int SIG_MEMR    = 4;
    localparam int SIG_IRW     = 5;
    localparam int SIG_MEMTOREG= 6;
    localparam int SIG_REGDST  = 7;
    localparam int SIG_REGW    = 8;
    localparam int SIG_ALUSRCA = 9;
    localparam int SIG_ALUSRCB = 10;  // two bits: 11:10
    localparam int SIG_PCSRC   = 12;

    // dmem_responder FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // True when a byte address does not point at a word boundary
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Single-port synchronous word RAM, DEPTH x 32 bits, no reset on contents.
// Ports:
//   clk   in   rising-edge clock
//   we    in   write enable; din is stored at idx on the edge
//   idx   in   word index (AW bits)
//   din   in   write data
//   dout  out  registered read of array[idx] taken every edge
// Read-during-write behaviour is unspecified; the responder never needs it.
// ---------------------------------------------------------------------------
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[idx] <= din;
        end
        dout <= r_mem[idx];
    end

endmodule

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Services one word read or write from the CPU datapath at a time. After a
// request is accepted in IDLE, WAIT_CYCLES wait states elapse, the access is
// performed on the internal array, and a single-cycle ready pulse is issued.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   mem_r      in   read request (MemR)
//   mem_w      in   write request (MemW); wins when both are high
//   addr       in   byte address; word index is addr[AW+1:2] (wraps)
//   wdata      in   store data
//   rdata      out  last read data, updated only when a read completes
//   ready      out  one-cycle completion pulse
//   busy       out  high from accept until the end of the ready cycle
//   err        out  misaligned access flag, valid with ready
//                   (present only when DMEM_ALIGN_CHECK_EN is defined)
//   dbg_state  out  current FSM state
//
// Handshake: a request is taken on any edge where the FSM is in IDLE and
// mem_r|mem_w is high; inputs are ignored from then until the FSM is back in
// IDLE. Completion is signalled by ready=1 for exactly one cycle, so the
// requester must drop or change its request in that cycle.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN (misaligned accesses suppress
// the write / return 0 on read and raise err with ready).
// ---------------------------------------------------------------------------
module dmem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
`ifdef DMEM_ALIGN_CHECK_EN
    output logic        err,
`endif
    output dmem_state_t dbg_state
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    dmem_state_t   r_state;
    dmem_state_t   w_next_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic          r_is_write;
    logic          r_misal;
    logic [31:0]   r_rdata;
    logic          r_ready;
    logic          r_busy;
    logic          r_err;

    logic          w_req;
    logic          w_access;
    logic          w_misal_now;
    logic          w_we;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_ram_dout;
    logic          w_unused;

    assign w_req    = mem_r | mem_w;
    assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misal_now = is_misaligned(addr[1:0]);
`else
    assign w_misal_now = 1'b0;
`endif

    // Address bits outside the word index are intentionally ignored.
    assign w_unused = ^{addr[31:AW+2], addr[1:0], r_err};

    // The RAM reads every edge. While IDLE it is pointed at the incoming
    // address so that, even with zero wait states, dout already holds the
    // accepted word by the access edge. Contents cannot change in between
    // because a read transaction never writes.
    assign w_ram_idx = (r_state == IDLE) ? addr[AW+1:2] : r_idx;

    // Gated by rst so a write whose access edge coincides with reset is
    // dropped rather than committed.
    assign w_we = w_access && r_is_write && !r_misal && !rst;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk  (clk),
        .we   (w_we),
        .idx  (w_ram_idx),
        .din  (r_wdata),
        .dout (w_ram_dout)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next_state = WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_wdata    <= 32'd0;
            r_is_write <= 1'b0;
            r_misal    <= 1'b0;
            r_rdata    <= 32'd0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_idx      <= addr[AW+1:2];
                        r_wdata    <= wdata;
                        r_is_write <= mem_w;
                        r_misal    <= w_misal_now;
                        r_cnt      <= CNT_INIT;
                        r_busy     <= 1'b1;
                    end
                end
                WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_ready <= 1'b1;
                        r_err   <= r_misal;
                        if (!r_is_write) begin
                            r_rdata <= r_misal ? 32'd0 : w_ram_dout;
                        end
                    end
                end
                DONE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rdata     = r_rdata;
    assign ready     = r_ready;
    assign busy      = r_busy;
    assign dbg_state = r_state;
`ifdef DMEM_ALIGN_CHECK_EN
    assign err       = r_err;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import cpu_pkg::*;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int POOL  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0
  logic        rst   [2];
  logic        mem_r [2];
  logic        mem_w [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  dmem_state_t dbg_state [2];
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err   [2];
`endif

  dmem_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst[0]), .mem_r(mem_r[0]), .mem_w(mem_w[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .ready(ready[0]), .busy(busy[0]),
`ifdef DMEM_ALIGN_CHECK_EN
    .err(err[0]),
`endif
    .dbg_state(dbg_state[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .AW(AW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst[1]), .mem_r(mem_r[1]), .mem_w(mem_w[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .ready(ready[1]), .busy(busy[1]),
`ifdef DMEM_ALIGN_CHECK_EN
    .err(err[1]),
`endif
    .dbg_state(dbg_state[1])
  );

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [int];   // key = dut*DEPTH + word index
  logic [31:0] model_rdata [2];
  logic [31:0] exp_q [$];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_txn(input int d, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] wd);
    int key;
    logic misal;
    logic [31:0] exp_rd;
    key = d * DEPTH + int'((a >> 2) % DEPTH);
    misal = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    misal = (a % 4) != 0;
`endif
    if (w) begin
      if (!misal) model_mem[key] = wd;
      exp_rd = model_rdata[d];
    end else begin
      if (misal) exp_rd = 32'd0;
      else if (model_mem.exists(key)) exp_rd = model_mem[key];
      else exp_rd = 32'd0;
      model_rdata[d] = exp_rd;
    end
    exp_q.push_back(exp_rd);

    mem_r[d] = r; mem_w[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    // garbage on the inputs while the transaction is in flight
    mem_r[d] = 1'($urandom_range(0, 1));
    mem_w[d] = 1'($urandom_range(0, 1));
    addr[d]  = $urandom;
    wdata[d] = $urandom;
    check($sformatf("d%0d busy_after_accept", d), 32'(busy[d]), 32'd1);
    check($sformatf("d%0d ready_after_accept", d), 32'(ready[d]), 32'd0);
    for (int k = 0; k < wait_of(d); k++) begin
      @(posedge clk); #1;
      check($sformatf("d%0d ready_wait%0d", d, k), 32'(ready[d]), 32'd0);
      check($sformatf("d%0d busy_wait%0d", d, k), 32'(busy[d]), 32'd1);
    end
    @(posedge clk); #1;
    mem_r[d] = 1'b0; mem_w[d] = 1'b0;
    check($sformatf("d%0d ready_pulse", d), 32'(ready[d]), 32'd1);
    check($sformatf("d%0d busy_done", d), 32'(busy[d]), 32'd1);
    check($sformatf("d%0d rdata_done a=%h", d, a), rdata[d], exp_q.pop_front());
`ifdef DMEM_ALIGN_CHECK_EN
    check($sformatf("d%0d err_done a=%h", d, a), 32'(err[d]), 32'(misal));
`endif
    @(posedge clk); #1;
    check($sformatf("d%0d ready_fall", d), 32'(ready[d]), 32'd0);
    check($sformatf("d%0d busy_fall", d), 32'(busy[d]), 32'd0);
    check($sformatf("d%0d rdata_hold", d), rdata[d], exp_rd);
    check($sformatf("d%0d state_idle", d), 32'(dbg_state[d]), 32'(IDLE));
`ifdef DMEM_ALIGN_CHECK_EN
    check($sformatf("d%0d err_fall", d), 32'(err[d]), 32'd0);
`endif
  endtask

  task automatic reset_mid_write(input int d, input logic [31:0] a, input logic [31:0] wd);
    mem_r[d] = 1'b0; mem_w[d] = 1'b1; addr[d] = a; wdata[d] = wd;
    @(posedge clk); #1;
    mem_w[d] = 1'b0;
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    model_rdata[d] = 32'd0;   // write dropped, rdata reset
    check($sformatf("d%0d rst_busy", d), 32'(busy[d]), 32'd0);
    check($sformatf("d%0d rst_rdata", d), rdata[d], 32'd0);
    check($sformatf("d%0d rst_state", d), 32'(dbg_state[d]), 32'(IDLE));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d%0d rst_no_ready%0d", d, k), 32'(ready[d]), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; mem_r[d] = 1'b0; mem_w[d] = 1'b0;
      addr[d] = 32'd0; wdata[d] = 32'd0; model_rdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d reset_rdata", d), rdata[d], 32'd0);
      check($sformatf("d%0d reset_ready", d), 32'(ready[d]), 32'd0);
      check($sformatf("d%0d reset_busy", d), 32'(busy[d]), 32'd0);
      check($sformatf("d%0d reset_state", d), 32'(dbg_state[d]), 32'(IDLE));
`ifdef DMEM_ALIGN_CHECK_EN
      check($sformatf("d%0d reset_err", d), 32'(err[d]), 32'd0);
`endif
    end

    // WAIT_CYCLES=2 directed sequence
    run_txn(0, 1'b0, 1'b1, 32'h10,   32'hDEADBEEF);
    run_txn(0, 1'b1, 1'b0, 32'h10,   32'h0);
    run_txn(0, 1'b0, 1'b1, 32'h1010, 32'h12345678);
    run_txn(0, 1'b1, 1'b0, 32'h0010, 32'h0);
    run_txn(0, 1'b1, 1'b1, 32'h20,   32'hA5A5A5A5);
    run_txn(0, 1'b1, 1'b0, 32'h20,   32'h0);
    run_txn(0, 1'b0, 1'b1, 32'h30,   32'h0);
    reset_mid_write(0, 32'h30, 32'h1);
    run_txn(0, 1'b1, 1'b0, 32'h30,   32'h0);

    // WAIT_CYCLES=0 back-to-back
    run_txn(1, 1'b0, 1'b1, 32'h40, 32'h5);
    run_txn(1, 1'b1, 1'b0, 32'h40, 32'h0);
    run_txn(1, 1'b0, 1'b1, 32'h50, 32'h77);
    reset_mid_write(1, 32'h50, 32'h99);
    run_txn(1, 1'b1, 1'b0, 32'h50, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
    run_txn(0, 1'b0, 1'b1, 32'h40, 32'h11);
    run_txn(0, 1'b0, 1'b1, 32'h42, 32'hFF);
    run_txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
    run_txn(0, 1'b1, 1'b0, 32'h43, 32'h0);
`endif

    // randomized traffic on a small index pool (pool first initialised)
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < POOL; i++) begin
        run_txn(d, 1'b0, 1'b1, ($urandom << (AW + 2)) | 32'((i + 64) << 2), $urandom);
      end
      for (int n = 0; n < 50; n++) begin
        logic r, w;
        logic [31:0] a;
        r = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        if (!r && !w) r = 1'b1;
        a = ($urandom << (AW + 2)) | 32'(($urandom_range(0, POOL - 1) + 64) << 2)
            | 32'($urandom_range(0, 3));
        run_txn(d, r, w, a, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
